// File: rtl/or8_if.sv
// Operand/result bundle for the or8 logic-op slice.
// The master drives operands and controls; the slave presents the registered result and flags.
interface or8_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             in_valid;
    logic             acc_en;
    logic             clr;
    logic [WIDTH-1:0] Z;
    logic             out_valid;
    logic             zero;
    logic             all_ones;
    logic             parity;

    modport master (
        output A, B, in_valid, acc_en, clr,
        input  Z, out_valid, zero, all_ones, parity
    );

    modport slave (
        input  A, B, in_valid, acc_en, clr,
        output Z, out_valid, zero, all_ones, parity
    );
endinterface

// File: rtl/or8.sv
// Registered bitwise-OR unit with optional accumulate into the held result.
// It also produces zero/all-ones/parity flags that are always consistent with the presented Z.
module or8 #(
    parameter int WIDTH = 8
) (
    input  logic  clk,
    input  logic  rst,
    or8_if.slave  bus
);
    logic [WIDTH-1:0] z_q, z_d;
    logic             out_valid_q, out_valid_d;
    logic             zero_q, zero_d;
    logic             all_ones_q, all_ones_d;
    logic             parity_q, parity_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        z_d         = z_q;
        out_valid_d = 1'b0;
        if (bus.clr) begin
            z_d = '0;
        end else if (bus.in_valid) begin
            z_d         = bus.acc_en ? (z_q | bus.A | bus.B) : (bus.A | bus.B);
            out_valid_d = 1'b1;
        end
        // Flags follow the next Z, so they land on the same edge as Z itself.
        zero_d     = (z_d == '0);
        all_ones_d = &z_d;
        parity_d   = ^z_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            z_q         <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b1;
            all_ones_q  <= 1'b0;
            parity_q    <= 1'b0;
        end else begin
            z_q         <= z_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
            all_ones_q  <= all_ones_d;
            parity_q    <= parity_d;
        end
    end

    assign bus.Z         = z_q;
    assign bus.out_valid = out_valid_q;
    assign bus.zero      = zero_q;
    assign bus.all_ones  = all_ones_q;
    assign bus.parity    = parity_q;
endmodule

// File: tb/tb_or8.sv
// Randomized scoreboard bench for or8: stimulus pushes expected results, a monitor pops them on out_valid.
// A behavioural model of the held result also gives a per-cycle check of out_valid, Z and flags.
module tb_or8;
    localparam int W = 8;
    localparam logic [W-1:0] ALL1 = {W{1'b1}};

    typedef struct {
        logic [W-1:0] z;
        logic         zero;
        logic         ones;
        logic         par;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    logic [W-1:0] model_z;

    or8_if #(.WIDTH(W)) bus ();
    or8 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t expect_of(input logic [W-1:0] z);
        exp_t e;
        e.z    = z;
        e.zero = (z == 0);
        e.ones = (z == ALL1);
        e.par  = ($countones(z) % 2) == 1;
        return e;
    endfunction

    // One clock of stimulus; model is updated from the operation rules, then the edge is taken.
    task automatic step(input logic r, input logic c, input logic v, input logic acc,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        logic accepted;
        exp_t e;
        rst          = r;
        bus.clr      = c;
        bus.in_valid = v;
        bus.acc_en   = acc;
        bus.A        = a;
        bus.B        = b;
        accepted = !r && !c && v;
        if (r || c)
            model_z = '0;
        else if (v)
            model_z = acc ? (model_z | a | b) : (a | b);
        if (accepted)
            sb_q.push_back(expect_of(model_z));
        @(posedge clk);
        #1;
        e = expect_of(model_z);
        check("out_valid", 64'(bus.out_valid), 64'(accepted));
        check("Z", 64'(bus.Z), 64'(e.z));
        check("zero", 64'(bus.zero), 64'(e.zero));
        check("all_ones", 64'(bus.all_ones), 64'(e.ones));
        check("parity", 64'(bus.parity), 64'(e.par));
    endtask

    // Monitor: decoupled from stimulus, compares whenever the DUT presents a result.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: out_valid=1 with no expected result at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_Z", 64'(bus.Z), 64'(e.z));
                check("sb_zero", 64'(bus.zero), 64'(e.zero));
                check("sb_all_ones", 64'(bus.all_ones), 64'(e.ones));
                check("sb_parity", 64'(bus.parity), 64'(e.par));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held;
        model_z = '0;
        rst = 1'b1;
        bus.clr = 1'b0; bus.in_valid = 1'b0; bus.acc_en = 1'b0; bus.A = '0; bus.B = '0;
        @(posedge clk); #1;

        // Reset for two cycles
        step(1, 0, 0, 0, 8'h00, 8'h00);
        step(1, 0, 0, 0, 8'h00, 8'h00);
        check("reset_Z", 64'(bus.Z), 64'h00);
        check("reset_zero", 64'(bus.zero), 64'h1);

        // Basic OR
        step(0, 0, 1, 0, 8'hF0, 8'h0C);
        check("basic_Z", 64'(bus.Z), 64'hFC);
        check("basic_parity", 64'(bus.parity), 64'h0);

        // Streaming, then an idle cycle holding 81
        step(0, 0, 1, 0, 8'h00, 8'h00);
        check("stream0_zero", 64'(bus.zero), 64'h1);
        step(0, 0, 1, 0, 8'hAA, 8'h55);
        check("stream1_all_ones", 64'(bus.all_ones), 64'h1);
        step(0, 0, 1, 0, 8'h81, 8'h00);
        step(0, 0, 0, 0, 8'h3C, 8'hC3);
        check("stream_hold_Z", 64'(bus.Z), 64'h81);
        check("stream_hold_ov", 64'(bus.out_valid), 64'h0);

        // Accumulate
        step(0, 0, 1, 0, 8'h01, 8'h00);
        step(0, 0, 1, 1, 8'h10, 8'h02);
        check("acc_Z", 64'(bus.Z), 64'h13);
        check("acc_parity", 64'(bus.parity), 64'h1);

        // Priority: clr and rst beat in_valid
        step(0, 0, 1, 0, 8'hF0, 8'h0C);
        step(0, 1, 1, 0, 8'hFF, 8'h00);
        check("clr_Z", 64'(bus.Z), 64'h00);
        check("clr_ov", 64'(bus.out_valid), 64'h0);
        step(1, 0, 1, 0, 8'hFF, 8'hFF);
        check("rst_Z", 64'(bus.Z), 64'h00);

        // Hold with random operands and in_valid low
        step(0, 0, 1, 0, 8'h5A, 8'h24);
        held = bus.Z;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, W'($urandom_range(0, 1)), W'($urandom), W'($urandom));
            check("hold_Z", 64'(bus.Z), 64'(held));
        end

        // Random mix, including accumulation chains, clears and resets
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 W'($urandom), W'($urandom));
        end

        step(0, 0, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
